// File: rtl/huffman_symbol_scheduler.sv
// Round-robin scheduler feeding one channel's symbol to a serial Huffman encoder
// and forwarding exactly L code bits per grant, with zero bubble between codes.
module huffman_symbol_scheduler #(
  parameter int NCH  = 4,
  parameter int SYMW = 5,
  parameter int LENW = 4,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH*SYMW-1:0]  req_sym,
  output logic [NCH-1:0]       req_ready,
  input  logic [NCH-1:0]       chan_en,
  output logic [SYMW-1:0]      len_query,
  input  logic [LENW-1:0]      len_resp,
  output logic                 enc_load,
  output logic [SYMW-1:0]      enc_sym,
  input  logic                 enc_bit,
  output logic                 out_bit,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [CW-1:0]        out_chan,
  output logic                 busy,
  output logic [15:0]          bit_count
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   owner_reg, owner_next;
  logic [LENW-1:0] remaining_reg, remaining_next;
  logic [CW-1:0]   out_chan_reg;
  logic [15:0]     bit_count_reg;

  logic [NCH-1:0]  eligible;
  logic [SYMW-1:0] syms [NCH];
  logic            found;
  logic [CW-1:0]   winner;
  logic [LENW-1:0] eff_len;

  assign eligible = req_valid & chan_en;
  assign eff_len  = (len_resp == '0) ? LENW'(1) : len_resp;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_sym
      assign syms[gi] = req_sym[gi*SYMW +: SYMW];
    end
  endgenerate

  // First eligible channel scanning upward from ptr, wrapping at NCH.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (int'(ptr_reg) + k) % NCH;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = CW'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      owner_reg     <= '0;
      remaining_reg <= '0;
      out_chan_reg  <= '0;
      bit_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      owner_reg     <= owner_next;
      remaining_reg <= remaining_next;
      out_chan_reg  <= out_chan;
      if (out_valid && bit_count_reg != 16'hFFFF)
        bit_count_reg <= bit_count_reg + 16'd1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    owner_next     = owner_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          ptr_next = (winner == CW'(NCH - 1)) ? '0 : winner + CW'(1);
          if (eff_len > LENW'(1)) begin
            state_next     = SHIFT;
            owner_next     = winner;
            remaining_next = eff_len - LENW'(1);
          end
        end
      end
      SHIFT: begin
        remaining_next = remaining_reg - LENW'(1);
        if (remaining_reg == LENW'(1))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant-cycle outputs are combinational so the first code bit leaves with the grant.
  always_comb begin
    req_ready = '0;
    enc_load  = 1'b0;
    enc_sym   = '0;
    len_query = '0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    out_chan  = out_chan_reg;
    busy      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          enc_load          = 1'b1;
          enc_sym           = syms[winner];
          len_query         = syms[winner];
          out_valid         = 1'b1;
          out_bit           = enc_bit;
          out_chan          = winner;
          out_last          = (eff_len == LENW'(1));
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_bit   = enc_bit;
        out_chan  = owner_reg;
        busy      = 1'b1;
        out_last  = (remaining_reg == LENW'(1));
      end
      default: ;
    endcase
  end

  assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_huffman_symbol_scheduler.sv
// Directed bench for huffman_symbol_scheduler; a negedge monitor checks every
// emitted bit against a queue of expected {channel, length} codes.
module tb_huffman_symbol_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [19:0] req_sym;
  logic [3:0]  req_ready;
  logic [3:0]  chan_en;
  logic [4:0]  len_query;
  logic [3:0]  len_resp;
  logic        enc_load;
  logic [4:0]  enc_sym;
  logic        enc_bit;
  logic        out_bit;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_chan;
  logic        busy;
  logic [15:0] bit_count;

  huffman_symbol_scheduler #(.NCH(4), .SYMW(5), .LENW(4)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_sym(req_sym),
    .req_ready(req_ready), .chan_en(chan_en), .len_query(len_query),
    .len_resp(len_resp), .enc_load(enc_load), .enc_sym(enc_sym),
    .enc_bit(enc_bit), .out_bit(out_bit), .out_valid(out_valid),
    .out_last(out_last), .out_chan(out_chan), .busy(busy), .bit_count(bit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int chan;
    int len;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   pos        = 0;
  logic [3:0] len_val;

  assign len_resp = len_val;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int ch, input int ln);
    exp_t e;
    e.chan = ch;
    e.len  = ln;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  initial begin
    enc_bit = 1'b0;
    forever begin
      @(posedge clock);
      #1 enc_bit = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: one line per emitted code bit compared against the queue head.
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        chk("out_chan", int'(out_chan), sb[0].chan);
        chk("out_last", int'(out_last), (pos == sb[0].len - 1) ? 1 : 0);
        chk("out_bit", int'(out_bit), int'(enc_bit));
        if (pos == sb[0].len - 1) begin
          void'(sb.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
    end
    if (reset === 1'b1) begin
      sb.delete();
      pos = 0;
    end
  end

  initial begin
    int nv;
    reset     = 1'b1;
    req_valid = '0;
    chan_en   = 4'b1111;
    req_sym   = {5'h13, 5'h0A, 5'h05, 5'h11};
    len_val   = 4'd1;

    // Reset state
    cyc(); cyc();
    at_neg();
    chk("rst_busy", int'(busy), 0);
    chk("rst_bit_count", int'(bit_count), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    chk("rst_enc_load", int'(enc_load), 0);
    cyc(); reset = 1'b0;

    // Single request on ch2, length 5
    cyc();
    req_valid = 4'b0100; len_val = 4'd5;
    push(2, 5);
    at_neg();
    chk("single_ready", int'(req_ready), 4'b0100);
    chk("single_load", int'(enc_load), 1);
    chk("single_enc_sym", int'(enc_sym), 5'h0A);
    chk("single_len_query", int'(len_query), 5'h0A);
    chk("single_busy_c1", int'(busy), 0);
    for (int b = 2; b <= 5; b++) begin
      cyc();
      if (b == 2) begin
        req_valid = '0; chan_en = 4'b1011; len_val = 4'd2;
      end
      at_neg();
      chk("single_busy", int'(busy), 1);
      chk("single_ready_shift", int'(req_ready), 0);
      chk("single_load_shift", int'(enc_load), 0);
    end
    cyc(); chan_en = 4'b1111;
    at_neg();
    chk("single_idle_valid", int'(out_valid), 0);
    chk("single_idle_busy", int'(busy), 0);
    chk("single_held_chan", int'(out_chan), 2);
    chk("single_bit_count", int'(bit_count), 5);
    chk("single_idle_sym", int'(enc_sym), 0);

    // Round-robin after reset: all valid, length 2
    cyc(); reset = 1'b1;
    at_neg();
    cyc();
    reset = 1'b0; req_valid = 4'b1111; len_val = 4'd2;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) cyc();
      if (c == 9) req_valid = '0;
      if (c % 2 == 0) push((c / 2) % 4, 2);
      at_neg();
      chk("rr_out_valid", int'(out_valid), 1);
      if (c % 2 == 0) chk("rr_ready", int'(req_ready), 1 << ((c / 2) % 4));
    end
    cyc();
    at_neg();
    chk("rr_done_valid", int'(out_valid), 0);

    // len_resp = 0 behaves as a 1-bit code
    cyc(); req_valid = 4'b0010; len_val = 4'd0;
    push(1, 1);
    at_neg();
    chk("len0_last", int'(out_last), 1);
    chk("len0_ready", int'(req_ready), 4'b0010);
    cyc(); req_valid = '0;
    at_neg();
    chk("len0_busy_after", int'(busy), 0);

    // len_resp = 15
    cyc(); req_valid = 4'b1000; len_val = 4'd15;
    push(3, 15);
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) cyc();
      if (i == 1) req_valid = '0;
      at_neg();
      if (out_valid === 1'b1) nv++;
    end
    chk("len15_count", nv, 15);

    // Masking by chan_en
    cyc(); req_valid = 4'b0001; chan_en = 4'b1110; len_val = 4'd1;
    at_neg();
    chk("mask_ready", int'(req_ready), 0);
    chk("mask_valid", int'(out_valid), 0);
    cyc();
    at_neg();
    chk("mask_ready2", int'(req_ready), 0);
    cyc(); chan_en = 4'b1111;
    push(0, 1);
    at_neg();
    chk("unmask_ready", int'(req_ready), 4'b0001);
    cyc(); req_valid = '0;

    // Reset on the 3rd bit of a 7-bit code
    cyc(); req_valid = 4'b0010; len_val = 4'd7;
    push(1, 7);
    at_neg();
    chk("rst7_ready", int'(req_ready), 4'b0010);
    cyc(); req_valid = '0;
    at_neg();
    cyc(); reset = 1'b1; req_valid = 4'b0001; len_val = 4'd3;
    at_neg();
    chk("rst7_no_last", int'(out_last), 0);
    chk("rst7_bit3_valid", int'(out_valid), 1);
    cyc(); reset = 1'b0;
    push(0, 3);
    at_neg();
    chk("rst7_bit_count", int'(bit_count), 0);
    chk("rst7_busy", int'(busy), 0);
    chk("rst7_ch0_grant", int'(req_ready), 4'b0001);
    cyc(); req_valid = '0;
    cyc(); cyc();

    // bit_count saturation
    cyc(); reset = 1'b1;
    at_neg();
    cyc(); reset = 1'b0; req_valid = 4'b1111; len_val = 4'd15;
    for (int c = 0; c < 65550; c++) begin
      if (c > 0) cyc();
      if (c % 15 == 0) push((c / 15) % 4, 15);
      at_neg();
      if (c == 65534) chk("sat_fffe", int'(bit_count), 16'hFFFE);
      if (c == 65535) chk("sat_ffff", int'(bit_count), 16'hFFFF);
      if (c == 65537) chk("sat_after3", int'(bit_count), 16'hFFFF);
      if (c == 65549) chk("sat_hold", int'(bit_count), 16'hFFFF);
    end
    cyc(); req_valid = '0;
    at_neg();
    chk("sat_idle_valid", int'(out_valid), 0);

    for (int w = 0; w < 20 && sb.size() != 0; w++) cyc();
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
